lpc_io_dispatch: RTL

Sequences the `lpc_periph` data-provider handshake and shares it between `NUM_TGT` register targets, e.g. TPM register file and POST-code port. Each LPC I/O cycle's 16-bit address is decoded against per-target base/mask windows. The block issues a one-cycle strobe to the winning target, waits for its ack under a timeout, and completes the `lpc_periph` handshake. Unclaimed or timed-out cycles complete with default data, so the host never hangs in long-wait SYNC.

---
 rtl/lpc_io_dispatch_pkg.sv | 29 ++
 rtl/lpc_io_dispatch_addr_decode.sv | 43 ++++
 rtl/lpc_io_dispatch.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lpc_io_dispatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lpc_io_dispatch_pkg                                        |
// | Description : Shared types and constants for the LPC I/O dispatcher:     |
// |               FSM state encodings, the default read data returned for    |
// |               unclaimed or timed-out cycles, and a saturating increment. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lpc_io_dispatch_pkg;

  // Dispatcher FSM states.
  typedef enum logic [1:0] {
    LPC_DISP_IDLE  = 2'd0,
    LPC_DISP_WAIT  = 2'd1,
    LPC_DISP_DONE  = 2'd2,
    LPC_DISP_DRAIN = 2'd3
  } lpc_disp_state_e;

  // Read data returned when no target claims the cycle or the target times out.
  localparam logic [7:0] c_LPC_DISP_MISS_DATA = 8'hFF;

  // 8-bit increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lpc_io_dispatch_addr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lpc_addr_decode                                            |
// | Description : Combinational priority window match of a 16-bit LPC I/O    |
// |               address against NUM_TGT base/mask windows. The lowest      |
// |               matching index wins.                                       |
// | Ports       : i_addr    - address to decode                              |
// |               o_hit     - one-hot winning target (all zero on miss)      |
// |               o_any_hit - some window matched                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lpc_addr_decode
  import lpc_io_dispatch_pkg::*;
#(
  parameter int                    NUM_TGT  = 2,
  parameter logic [NUM_TGT*16-1:0] TGT_BASE = {16'hFF00, 16'h0080},
  parameter logic [NUM_TGT*16-1:0] TGT_MASK = {16'hFF00, 16'hFFFF}
) (
  input  logic [15:0]        i_addr,
  output logic [NUM_TGT-1:0] o_hit,
  output logic               o_any_hit
);

  logic w_found;

  // Scan upwards; once a window matches, later (higher) indices are masked.
  always_comb begin
    o_hit   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (!w_found &&
          ((i_addr & TGT_MASK[16*i +: 16]) == (TGT_BASE[16*i +: 16] & TGT_MASK[16*i +: 16]))) begin
        o_hit[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign o_any_hit = w_found;

endmodule

`default_nettype wire

// File: rtl/lpc_io_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lpc_io_dispatch                                            |
// | Description : Sequences the lpc_periph data-provider handshake and       |
// |               shares it among NUM_TGT register targets. Each I/O cycle   |
// |               is decoded to a target, strobed, and completed on ack,     |
// |               on timeout (data FF) or immediately on a miss (data FF).   |
// | Ports       : clk_i, rst_i        - clock, sync active-high reset        |
// |               lpc_addr_i          - cycle address from lpc_periph        |
// |               lpc_data_io         - write data in / read data out        |
// |               lpc_data_wr/_req    - write / read pending (levels)        |
// |               lpc_wr_done         - write accepted                       |
// |               lpc_data_rd         - read data valid on lpc_data_io       |
// |               tgt_wr_o/tgt_rd_o   - one-hot 1-cycle target strobes       |
// |               tgt_addr_o/_wdata_o - latched address / write data         |
// |               tgt_rdata_i/_ack_i  - per-target read data and ack pulse   |
// |               tmo_count_o         - saturating timeout count             |
// |               miss_count_o        - saturating unclaimed-cycle count     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lpc_io_dispatch
  import lpc_io_dispatch_pkg::*;
#(
  parameter int                    NUM_TGT        = 2,
  parameter logic [NUM_TGT*16-1:0] TGT_BASE       = {16'hFF00, 16'h0080},
  parameter logic [NUM_TGT*16-1:0] TGT_MASK       = {16'hFF00, 16'hFFFF},
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [15:0]          lpc_addr_i,
  inout  wire  [7:0]           lpc_data_io,
  input  logic                 lpc_data_wr,
  input  logic                 lpc_data_req,
  output logic                 lpc_wr_done,
  output logic                 lpc_data_rd,
  output logic [NUM_TGT-1:0]   tgt_wr_o,
  output logic [NUM_TGT-1:0]   tgt_rd_o,
  output logic [15:0]          tgt_addr_o,
  output logic [7:0]           tgt_wdata_o,
  input  logic [NUM_TGT*8-1:0] tgt_rdata_i,
  input  logic [NUM_TGT-1:0]   tgt_ack_i,
  output logic [7:0]           tmo_count_o,
  output logic [7:0]           miss_count_o
);

  localparam int                  c_TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMR_W-1:0]  c_TMR_MAX = c_TMR_W'(TIMEOUT_CYCLES);
  localparam logic [c_TMR_W-1:0]  c_TMR_ONE = c_TMR_W'(1);

  lpc_disp_state_e      r_state;
  logic [NUM_TGT-1:0]   r_sel;
  logic [NUM_TGT-1:0]   r_tgt_wr;
  logic [NUM_TGT-1:0]   r_tgt_rd;
  logic [15:0]          r_addr;
  logic [7:0]           r_wdata;
  logic [7:0]           r_rdata;
  logic                 r_wr_done;
  logic                 r_data_rd;
  logic [c_TMR_W-1:0]   r_timer;
  logic [7:0]           r_tmo_cnt;
  logic [7:0]           r_miss_cnt;

  logic [NUM_TGT-1:0]   w_hit;
  logic                 w_any_hit;
  logic                 w_req_any;
  logic                 w_ack;
  logic                 w_tmo;
  logic [7:0]           w_sel_rdata;

  // Decode the live bus address; it is only consumed in IDLE when a request
  // is sampled, at which point the same address is latched.
  lpc_addr_decode #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decode (
    .i_addr    (lpc_addr_i),
    .o_hit     (w_hit),
    .o_any_hit (w_any_hit)
  );

  assign w_req_any = lpc_data_wr | lpc_data_req;
  // Only the selected target's ack counts; others are masked off.
  assign w_ack     = |(tgt_ack_i & r_sel);
  assign w_tmo     = (r_timer == c_TMR_MAX);

  // One-hot read-data mux on the latched selection.
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = w_sel_rdata | tgt_rdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= LPC_DISP_IDLE;
      r_sel      <= '0;
      r_tgt_wr   <= '0;
      r_tgt_rd   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wr_done  <= 1'b0;
      r_data_rd  <= 1'b0;
      r_timer    <= '0;
      r_tmo_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      // Strobes are single-cycle pulses.
      r_tgt_wr <= '0;
      r_tgt_rd <= '0;

      case (r_state)
        LPC_DISP_IDLE: begin
          if (w_req_any) begin
            r_addr  <= lpc_addr_i;
            r_timer <= '0;
            if (lpc_data_wr) begin
              r_wdata <= lpc_data_io;
            end
            if (w_any_hit) begin
              r_sel <= w_hit;
              // A simultaneous write and read request is handled as a write.
              if (lpc_data_wr) begin
                r_tgt_wr <= w_hit;
              end else begin
                r_tgt_rd <= w_hit;
              end
              r_state <= LPC_DISP_WAIT;
            end else begin
              r_sel      <= '0;
              r_rdata    <= c_LPC_DISP_MISS_DATA;
              r_miss_cnt <= sat_inc8(r_miss_cnt);
              r_wr_done  <= lpc_data_wr;
              r_data_rd  <= ~lpc_data_wr;
              r_state    <= LPC_DISP_DONE;
            end
          end
        end

        LPC_DISP_WAIT: begin
          if (!w_req_any) begin
            // Host side gave up. If the target has already finished there
            // is nothing to absorb, otherwise wait for it in DRAIN.
            if (w_ack || w_tmo) begin
              r_state <= LPC_DISP_IDLE;
            end else begin
              r_timer <= r_timer + c_TMR_ONE;
              r_state <= LPC_DISP_DRAIN;
            end
          end else if (w_ack) begin
            // The ack takes priority over a timeout in the same cycle.
            if (r_tgt_is_read()) begin
              r_rdata <= w_sel_rdata;
            end
            r_wr_done <= lpc_data_wr;
            r_data_rd <= ~lpc_data_wr;
            r_state   <= LPC_DISP_DONE;
          end else if (w_tmo) begin
            r_rdata   <= c_LPC_DISP_MISS_DATA;
            r_tmo_cnt <= sat_inc8(r_tmo_cnt);
            r_wr_done <= lpc_data_wr;
            r_data_rd <= ~lpc_data_wr;
            r_state   <= LPC_DISP_DONE;
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end

        LPC_DISP_DONE: begin
          if (!w_req_any) begin
            r_wr_done <= 1'b0;
            r_data_rd <= 1'b0;
            r_state   <= LPC_DISP_IDLE;
          end
        end

        LPC_DISP_DRAIN: begin
          if (w_ack || w_tmo) begin
            r_state <= LPC_DISP_IDLE;
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end

        default: r_state <= LPC_DISP_IDLE;
      endcase
    end
  end

  // The request kind is carried by the live request lines, which lpc_periph
  // holds stable for the whole cycle.
  function automatic logic r_tgt_is_read();
    return ~lpc_data_wr;
  endfunction

  assign lpc_wr_done  = r_wr_done;
  assign lpc_data_rd  = r_data_rd;
  assign lpc_data_io  = r_data_rd ? r_rdata : 8'hzz;
  assign tgt_wr_o     = r_tgt_wr;
  assign tgt_rd_o     = r_tgt_rd;
  assign tgt_addr_o   = r_addr;
  assign tgt_wdata_o  = r_wdata;
  assign tmo_count_o  = r_tmo_cnt;
  assign miss_count_o = r_miss_cnt;

endmodule

`default_nettype wire
